// File: rtl/mux_si_sched.sv
// Slot scheduler: parses config/table packets, forwards payload bytes and walks a
// per-slot section table, emitting one descriptor per live section on each scan.
module mux_si_sched #(
    parameter int SLOT_W   = 10,
    parameter int SEC_W    = 4,
    parameter int CC_W     = 4,
    parameter int TICK_DIV = 50,
    parameter int BW_RST   = 40
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    cfg_din,
    input  logic                          cfg_din_en,
    input  logic [7:0]                    tab_din,
    input  logic                          tab_din_en,
    output logic [7:0]                    pay_dout,
    output logic                          pay_dout_en,
    output logic [CC_W+1+SLOT_W+SEC_W-1:0] desc_dout,
    output logic                          desc_valid,
    input  logic                          desc_ready,
    output logic                          busy,
    output logic [15:0]                   drop_cnt
);
    localparam int DEPTH  = 1 << SLOT_W;
    localparam int ENT_W  = CC_W + SEC_W;
    localparam int DESC_W = CC_W + 1 + SLOT_W + SEC_W;
    localparam int DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [2:0] {CLR, IDLE, WR_RD, WR_WB, SC_RD, SC_EVAL, SC_EMIT, SC_WB} state_t;
    state_t state_q, state_d;

    logic [7:0]        cfg_idx_q, cfg_idx, tab_idx_q, tab_idx;
    logic              cfg_en_q, tab_en_q;
    logic [7:0]        slot_hi, slot_lo;
    logic [SEC_W-1:0]  cfg_n;
    logic              wr_pend;
    logic [SLOT_W-1:0] wr_slot_q, act_slot;
    logic [SEC_W-1:0]  wr_n_q, act_n;
    logic [15:0]       bw, per_cnt;
    logic [DIV_W-1:0]  div_cnt;
    logic              tick, scan_req, scan_pend, scan_take, wr_take;
    logic [SLOT_W-1:0] clr_ptr, scan_ptr, rd_addr, mem_waddr;
    logic [SEC_W-1:0]  sec_idx;
    logic [ENT_W-1:0]  mem [DEPTH];
    logic [ENT_W-1:0]  rd_data, ent_q, mem_wdata;
    logic              mem_we;
    logic [DESC_W-1:0] desc_q;
    logic [CC_W-1:0]   rd_cc, ent_cc;
    logic [SEC_W-1:0]  rd_n, ent_n;

    assign rd_cc  = rd_data[ENT_W-1:SEC_W];
    assign rd_n   = rd_data[SEC_W-1:0];
    assign ent_cc = ent_q[ENT_W-1:SEC_W];
    assign ent_n  = ent_q[SEC_W-1:0];

    // Byte index restarts at 0 on the first enabled cycle of each packet and sticks at 255.
    always_comb begin
        cfg_idx = 8'd0;
        tab_idx = 8'd0;
        if (cfg_en_q) cfg_idx = (cfg_idx_q == 8'hFF) ? 8'hFF : cfg_idx_q + 8'd1;
        if (tab_en_q) tab_idx = (tab_idx_q == 8'hFF) ? 8'hFF : tab_idx_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_en_q    <= 1'b0;
            cfg_idx_q   <= 8'd0;
            tab_en_q    <= 1'b0;
            tab_idx_q   <= 8'd0;
            bw          <= 16'(BW_RST);
            pay_dout    <= 8'd0;
            pay_dout_en <= 1'b0;
            wr_pend     <= 1'b0;
        end else begin
            cfg_en_q    <= cfg_din_en;
            tab_en_q    <= tab_din_en;
            pay_dout    <= 8'd0;
            pay_dout_en <= 1'b0;
            if (cfg_din_en) cfg_idx_q <= cfg_idx;
            if (tab_din_en) tab_idx_q <= tab_idx;
            if (cfg_din_en && cfg_idx >= 8'd11 && cfg_n != '0) begin
                pay_dout    <= cfg_din;
                pay_dout_en <= 1'b1;
            end
            if (tab_din_en && tab_idx == 8'd6) bw[15:8] <= tab_din;
            if (tab_din_en && tab_idx == 8'd7) bw[7:0]  <= tab_din;
            // A fresh byte 10 wins over the IDLE hand-off in the same cycle.
            if (cfg_din_en && cfg_idx == 8'd10) wr_pend <= 1'b1;
            else if (wr_take)                   wr_pend <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (cfg_din_en && cfg_idx == 8'd8) slot_hi <= cfg_din;
        if (cfg_din_en && cfg_idx == 8'd9) slot_lo <= cfg_din;
        if (cfg_din_en && cfg_idx == 8'd10) begin
            cfg_n     <= cfg_din[SEC_W-1:0];
            wr_n_q    <= cfg_din[SEC_W-1:0];
            wr_slot_q <= SLOT_W'({slot_hi, slot_lo});
        end
        if (wr_take) begin
            act_slot <= wr_slot_q;
            act_n    <= wr_n_q;
        end
        if (state_q == SC_EVAL) ent_q <= rd_data;
    end

    assign tick      = (per_cnt >= bw);
    assign scan_req  = tick && (div_cnt == DIV_W'(TICK_DIV - 1));
    assign wr_take   = (state_q == IDLE) && wr_pend;
    assign scan_take = (state_q == IDLE) && !wr_pend && scan_pend;

    always_ff @(posedge clk) begin
        if (rst) begin
            per_cnt   <= 16'd0;
            div_cnt   <= '0;
            scan_pend <= 1'b0;
            drop_cnt  <= 16'd0;
        end else begin
            per_cnt <= tick ? 16'd0 : per_cnt + 16'd1;
            if (tick) div_cnt <= scan_req ? '0 : div_cnt + DIV_W'(1);
            if (scan_req && state_q != CLR) begin
                if (scan_pend && !scan_take) begin
                    if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
                end else begin
                    scan_pend <= 1'b1;
                end
            end else if (scan_take) begin
                scan_pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= CLR;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            CLR:     if (clr_ptr == {SLOT_W{1'b1}}) state_d = IDLE;
            IDLE:    if (wr_pend) state_d = WR_RD;
                     else if (scan_pend) state_d = SC_RD;
            WR_RD:   state_d = WR_WB;
            WR_WB:   state_d = IDLE;
            SC_RD:   state_d = SC_EVAL;
            SC_EVAL: state_d = (rd_n > sec_idx) ? SC_EMIT : IDLE;
            SC_EMIT: if (desc_ready) state_d = SC_WB;
            SC_WB:   state_d = IDLE;
            default: state_d = CLR;
        endcase
    end

    always_comb begin
        busy       = 1'b0;
        desc_valid = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = scan_ptr;
        mem_wdata  = '0;
        rd_addr    = scan_ptr;
        case (state_q)
            CLR: begin
                busy      = 1'b1;
                mem_we    = 1'b1;
                mem_waddr = clr_ptr;
            end
            WR_RD: rd_addr = act_slot;
            WR_WB: begin
                mem_we    = 1'b1;
                mem_waddr = act_slot;
                mem_wdata = {rd_cc, act_n};
            end
            SC_EMIT: desc_valid = 1'b1;
            SC_WB: begin
                mem_we    = 1'b1;
                mem_wdata = {ent_cc + CC_W'(1), ent_n};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
        rd_data <= mem[rd_addr];
    end

    // Scan pointer advances once per finished scan; sec_idx steps when it wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            clr_ptr  <= '0;
            scan_ptr <= '0;
            sec_idx  <= '0;
            desc_q   <= '0;
        end else begin
            if (state_q == CLR) clr_ptr <= clr_ptr + SLOT_W'(1);
            if ((state_q == SC_EVAL && !(rd_n > sec_idx)) || state_q == SC_WB) begin
                scan_ptr <= scan_ptr + SLOT_W'(1);
                if (scan_ptr == {SLOT_W{1'b1}}) sec_idx <= sec_idx + SEC_W'(1);
            end
            if (state_q == SC_EVAL) desc_q <= {rd_cc, 1'b1, scan_ptr, sec_idx};
        end
    end

    assign desc_dout = desc_q;
endmodule

// File: doc/mux_si_sched.md
MUX_SI_SCHED -- requirements
Module: mux_si_sched

Interface
REQ-001 SHALL have parameter SLOT_W, default 10, slot address width; table depth is 2^SLOT_W.
REQ-002 SHALL have parameter SEC_W, default 4, section-count and section-index width.
REQ-003 SHALL have parameter CC_W, default 4, per-slot continuity-counter width.
REQ-004 SHALL have parameter TICK_DIV, default 50, number of bandwidth ticks per scan request (>=1).
REQ-005 SHALL have parameter BW_RST, default 40, bandwidth period loaded at reset.
REQ-006 clk  in  1  clock; all logic rising-edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 cfg_din  in  8  slot-config packet byte; cfg_din_en  in  1  high for the contiguous length of one packet.
REQ-009 tab_din  in  8  table-parameter byte; tab_din_en  in  1  high for the contiguous length of one packet.
REQ-010 pay_dout  out  8  payload byte forwarded to DDR; pay_dout_en  out  1  payload byte valid.
REQ-011 desc_dout  out  CC_W+1+SLOT_W+SEC_W  descriptor {cc, 1'b1, slot, sec_idx}; desc_valid  out  1; desc_ready  in  1.
REQ-012 busy  out  1  table clear in progress; drop_cnt  out  16  saturating count of dropped scan requests.

Function
REQ-013 Config byte index SHALL be 0 on the first cfg_din_en cycle, increment per enabled cycle, saturate at 255, and restart at 0 on the next packet.
REQ-014 Byte 8 and byte 9 SHALL form slot = {b8,b9}[SLOT_W-1:0]; byte 10 bits [SEC_W-1:0] SHALL form section count N.
REQ-015 At byte 10 a pending write {slot,N} SHALL be latched; a newer byte 10 overwrites an unserved pending write (latest wins).
REQ-016 Bytes with index >=11 SHALL appear on pay_dout with pay_dout_en=1 one cycle later iff N!=0; otherwise pay_dout=0 and pay_dout_en=0.
REQ-017 Table bytes 6 and 7 SHALL load bandwidth period BW[15:8] and BW[7:0] respectively.
REQ-018 Period counter SHALL count 0..BW and emit one tick when equal to BW, then restart at 0; BW=0 means a tick every cycle.
REQ-019 Every TICK_DIV ticks SHALL raise one scan request.
REQ-020 Table entry SHALL be {cc[CC_W], N[SEC_W]}, held in internal RAM with 1-cycle registered read latency.
REQ-021 FSM states: CLR, IDLE, WR_RD, WR_WB, SC_RD, SC_EVAL, SC_EMIT, SC_WB.
REQ-022 CLR SHALL write zero to every entry, one per cycle, then go to IDLE; busy=1 only in CLR.
REQ-023 IDLE SHALL serve a pending write before a pending scan request.
REQ-024 Write path: WR_RD reads slot; WR_WB writes {old cc, N}; N=0 erases the slot; return to IDLE.
REQ-025 Scan path: SC_RD reads entry at scan_ptr; SC_EVAL compares N with sec_idx.
REQ-026 If N > sec_idx, SC_EMIT SHALL drive desc_valid=1 with {cc,1,scan_ptr,sec_idx}, held stable until desc_ready=1.
REQ-027 After the handshake, SC_WB SHALL write {cc+1 mod 2^CC_W, N}.
REQ-028 If N <= sec_idx, no descriptor SHALL be emitted and the entry SHALL stay unchanged.
REQ-029 At the end of every scan, scan_ptr SHALL increment.
REQ-030 When scan_ptr wraps from 2^SLOT_W-1 to 0, sec_idx SHALL increment mod 2^SEC_W.
REQ-031 One scan request SHALL be buffered while the FSM is not in IDLE.
REQ-032 A scan request arriving while one is already buffered SHALL be dropped, and drop_cnt SHALL increment, saturating at 65535.
REQ-033 Scan requests arriving during CLR SHALL be discarded and not counted; pending writes SHALL be held until CLR ends.
REQ-034 A write and a scan to the same slot SHALL never overlap; each completes its read-modify-write before the other starts.

Reset
REQ-035 On rst, the FSM SHALL enter CLR and the following SHALL be zeroed: scan_ptr, sec_idx, counters, pending flags, drop_cnt, pay_dout, pay_dout_en, desc_dout, desc_valid.
REQ-036 On rst, BW SHALL be set to BW_RST.
REQ-037 rst asserted mid-operation SHALL abort any handshake in progress; desc_valid SHALL fall the next cycle.

Verification
REQ-038 Reset, then wait for busy to fall: busy is high for exactly 2^SLOT_W cycles and every slot reads as zero.
REQ-039 Config packet slot=0x005, N=2, 20 bytes: 9 pay_dout_en pulses at 1-cycle latency; the same packet with N=0 gives no pay_dout_en.
REQ-040 BW=0, TICK_DIV=1, slot 5 N=2, desc_ready=1: slot 5 descriptors appear in pass sec_idx 0 and pass sec_idx 1 with cc=0 then cc=1, and none in pass sec_idx 2.
REQ-041 desc_ready=0 for 100 cycles with requests every cycle: desc_valid and desc_dout stay stable, and drop_cnt counts every request after the first buffered one.
REQ-042 Write to slot 5 issued while slot 5 is in SC_EMIT: the write is applied after SC_WB and the cc increment is preserved.
REQ-043 Assert rst during SC_EMIT: desc_valid=0 next cycle, busy rises, BW=BW_RST.
